jag_bus_arbiter: RTL and testbench

Sequences ownership of the shared system bus between the 68000 (default owner) and up to NREQ internal bus masters (GPU, DSP, blitter, object processor). It runs the 68000 BR/BG/BGACK handshake, picks a winner by fixed priority with hold-time preemption, and drives `ba` into the CPU bus interface so that block stops issuing 68000 cycles while another master owns the bus. Ownership changes only between transfers, never while a request/ack cycle is in flight.

---
 rtl/jag_bus_arbiter_if.sv | 36 +++
 rtl/jag_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_jag_bus_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/jag_bus_arbiter_if.sv
// Bus-ownership handshake bundle between the arbiter, the 68000 and the internal masters.
// The arbiter connects through the slave modport; the requester side connects through master.
interface jag_bus_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] breq;
    logic            busy;
    logic            cpu_asl;
    logic            bgl;
    logic            brl;
    logic            bgackl;
    logic [NREQ-1:0] gnt;
    logic            ba;

    modport slave (
        input  breq,
        input  busy,
        input  cpu_asl,
        input  bgl,
        output brl,
        output bgackl,
        output gnt,
        output ba
    );

    modport master (
        output breq,
        output busy,
        output cpu_asl,
        output bgl,
        input  brl,
        input  bgackl,
        input  gnt,
        input  ba
    );
endinterface

// File: rtl/jag_bus_arbiter.sv
// Hands the system bus between the 68000 and the internal masters using BR/BG/BGACK.
// It uses fixed priority (bit 0 highest) and preempts an owner that holds the bus too long.
module jag_bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int HOLD_MAX = 16
) (
    input  logic               sys_clk,
    input  logic               resetl,
    input  logic               ce_i,
    jag_bus_arbiter_if.slave   bus
);

    localparam int HW = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {
        ST_CPU,
        ST_REQ,
        ST_OWN,
        ST_TURN
    } state_t;

    state_t          state_q,   state_d;
    logic [NREQ-1:0] grant_q,   grant_d;
    logic [NREQ-1:0] mask_q,    mask_d;
    logic [HW-1:0]   holdCnt_q, holdCnt_d;
    logic            brl_q,     brl_d;
    logic            bgackl_q,  bgackl_d;
    logic            ba_q,      ba_d;

    logic [NREQ-1:0] others;
    logic [NREQ-1:0] eligible;
    logic            holdExpired;

    function automatic logic [NREQ-1:0] lowestBit(input logic [NREQ-1:0] v);
        logic [NREQ-1:0] r;
        r = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    assign others      = bus.breq & ~grant_q;
    assign eligible    = bus.breq & ~mask_q;
    assign holdExpired = (holdCnt_q == HW'(HOLD_MAX));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        mask_d    = mask_q;
        holdCnt_d = holdCnt_q;
        brl_d     = brl_q;
        bgackl_d  = bgackl_q;
        ba_d      = ba_q;
        unique case (state_q)
            ST_CPU: begin
                if (bus.breq != '0) begin
                    state_d = ST_REQ;
                    brl_d   = 1'b0;
                end
            end
            ST_REQ: begin
                if (bus.breq == '0) begin
                    state_d = ST_CPU;
                    brl_d   = 1'b1;
                end else if (!bus.bgl && bus.cpu_asl && !bus.busy) begin
                    state_d   = ST_OWN;
                    grant_d   = lowestBit(bus.breq);
                    holdCnt_d = '0;
                    brl_d     = 1'b1;
                    bgackl_d  = 1'b0;
                    ba_d      = 1'b1;
                end
            end
            ST_OWN: begin
                if (others != '0 && !holdExpired) begin
                    holdCnt_d = holdCnt_q + 1'b1;
                end
                // Release is tested first so a releasing owner is never also masked.
                if (!bus.busy) begin
                    if ((bus.breq & grant_q) == '0) begin
                        state_d = ST_TURN;
                        grant_d = '0;
                        mask_d  = '0;
                    end else if (holdExpired && others != '0) begin
                        state_d = ST_TURN;
                        grant_d = '0;
                        mask_d  = grant_q;
                    end
                end
            end
            ST_TURN: begin
                mask_d    = '0;
                holdCnt_d = '0;
                if (eligible != '0) begin
                    state_d = ST_OWN;
                    grant_d = lowestBit(eligible);
                end else begin
                    state_d  = ST_CPU;
                    bgackl_d = 1'b1;
                    ba_d     = 1'b0;
                end
            end
            default: begin
                state_d = ST_CPU;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            state_q   <= ST_CPU;
            grant_q   <= '0;
            mask_q    <= '0;
            holdCnt_q <= '0;
            brl_q     <= 1'b1;
            bgackl_q  <= 1'b1;
            ba_q      <= 1'b0;
        end else if (ce_i) begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            mask_q    <= mask_d;
            holdCnt_q <= holdCnt_d;
            brl_q     <= brl_d;
            bgackl_q  <= bgackl_d;
            ba_q      <= ba_d;
        end
    end

    assign bus.brl    = brl_q;
    assign bus.bgackl = bgackl_q;
    assign bus.gnt    = grant_q;
    assign bus.ba     = ba_q;

endmodule

// File: tb/tb_jag_bus_arbiter.sv
// Directed bench for jag_bus_arbiter with NREQ=4 and HOLD_MAX=8.
// Each step is one ce cycle, and outputs are compared 1 ns after the clock edge.
module tb_jag_bus_arbiter;

    logic sysClk;
    logic resetl;
    logic ce;
    int   checks;
    int   failures;

    jag_bus_arbiter_if #(.NREQ(4)) bus ();

    jag_bus_arbiter #(
        .NREQ     (4),
        .HOLD_MAX (8)
    ) dut (
        .sys_clk (sysClk),
        .resetl  (resetl),
        .ce_i    (ce),
        .bus     (bus)
    );

    // Free-running 100 MHz system clock
    initial begin
        sysClk = 1'b0;
        forever #5 sysClk = ~sysClk;
    end

    // Drive the requester-side inputs between clock edges
    task automatic applyStimulus(input logic [3:0] breq, input logic busy,
                                 input logic bgl, input logic cpuAsl);
        bus.breq    = breq;
        bus.busy    = busy;
        bus.bgl     = bgl;
        bus.cpu_asl = cpuAsl;
    endtask

    // Advance one bus clock: ce is high across exactly one sys_clk edge
    task automatic stepCe(input int n);
        for (int i = 0; i < n; i++) begin
            ce = 1'b1;
            @(posedge sysClk);
            #1;
        end
    endtask

    // Compare {brl, bgackl, gnt, ba} against a hand-computed expectation
    task automatic checkOutput(input string tag, input logic expBrl, input logic expBgackl,
                               input logic [3:0] expGnt, input logic expBa);
        logic [6:0] observed;
        logic [6:0] expected;
        observed = {bus.brl, bus.bgackl, bus.gnt, bus.ba};
        expected = {expBrl, expBgackl, expGnt, expBa};
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed brl,bgackl,gnt,ba=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Directed sequence covering every state transition and the corner cases
    initial begin
        checks   = 0;
        failures = 0;
        ce       = 1'b0;
        resetl   = 1'b0;
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1);
        stepCe(2);
        resetl = 1'b1;
        checkOutput("reset_idle", 1'b1, 1'b1, 4'b0000, 1'b0);

        $display("[TB] basic grant");
        applyStimulus(4'b0100, 1'b0, 1'b1, 1'b1);
        stepCe(1);
        checkOutput("basic_req", 1'b0, 1'b1, 4'b0000, 1'b0);
        stepCe(2);
        checkOutput("basic_wait_bgl", 1'b0, 1'b1, 4'b0000, 1'b0);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b1);
        stepCe(1);
        checkOutput("basic_own", 1'b1, 1'b0, 4'b0100, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1);
        ce = 1'b0;
        @(posedge sysClk);
        #1;
        checkOutput("ce_low_hold", 1'b1, 1'b0, 4'b0100, 1'b1);
        stepCe(1);
        checkOutput("basic_turn", 1'b1, 1'b0, 4'b0000, 1'b1);
        stepCe(1);
        checkOutput("basic_back_cpu", 1'b1, 1'b1, 4'b0000, 1'b0);

        $display("[TB] priority");
        applyStimulus(4'b1010, 1'b0, 1'b1, 1'b1);
        stepCe(1);
        checkOutput("prio_req", 1'b0, 1'b1, 4'b0000, 1'b0);
        applyStimulus(4'b1010, 1'b0, 1'b0, 1'b1);
        stepCe(1);
        checkOutput("prio_own_b1", 1'b1, 1'b0, 4'b0010, 1'b1);
        applyStimulus(4'b1000, 1'b0, 1'b1, 1'b1);
        stepCe(1);
        checkOutput("prio_turn", 1'b1, 1'b0, 4'b0000, 1'b1);
        stepCe(1);
        checkOutput("prio_own_b3", 1'b1, 1'b0, 4'b1000, 1'b1);

        $display("[TB] preemption");
        applyStimulus(4'b1001, 1'b0, 1'b1, 1'b1);
        stepCe(8);
        checkOutput("preempt_still_b3", 1'b1, 1'b0, 4'b1000, 1'b1);
        stepCe(1);
        checkOutput("preempt_turn", 1'b1, 1'b0, 4'b0000, 1'b1);
        stepCe(1);
        checkOutput("preempt_own_b0", 1'b1, 1'b0, 4'b0001, 1'b1);
        applyStimulus(4'b1000, 1'b0, 1'b1, 1'b1);
        stepCe(2);
        checkOutput("preempt_return_b3", 1'b1, 1'b0, 4'b1000, 1'b1);

        $display("[TB] busy blocking");
        applyStimulus(4'b1001, 1'b1, 1'b1, 1'b1);
        stepCe(8);
        for (int i = 0; i < 5; i++) begin
            stepCe(1);
            checkOutput($sformatf("busy_block_%0d", i), 1'b1, 1'b0, 4'b1000, 1'b1);
        end
        applyStimulus(4'b1001, 1'b0, 1'b1, 1'b1);
        stepCe(1);
        checkOutput("busy_release_turn", 1'b1, 1'b0, 4'b0000, 1'b1);
        stepCe(1);
        checkOutput("busy_own_b0", 1'b1, 1'b0, 4'b0001, 1'b1);

        $display("[TB] preempted master masked for one arbitration");
        stepCe(8);
        checkOutput("mask_still_b0", 1'b1, 1'b0, 4'b0001, 1'b1);
        stepCe(1);
        checkOutput("mask_turn", 1'b1, 1'b0, 4'b0000, 1'b1);
        stepCe(1);
        checkOutput("mask_own_b3", 1'b1, 1'b0, 4'b1000, 1'b1);
        applyStimulus(4'b0001, 1'b0, 1'b1, 1'b1);
        stepCe(2);
        checkOutput("mask_cleared_b0", 1'b1, 1'b0, 4'b0001, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1);
        stepCe(1);
        checkOutput("last_release_turn", 1'b1, 1'b0, 4'b0000, 1'b1);
        stepCe(1);
        checkOutput("last_release_cpu", 1'b1, 1'b1, 4'b0000, 1'b0);

        $display("[TB] 68000 handshake");
        applyStimulus(4'b0001, 1'b0, 1'b1, 1'b1);
        stepCe(1);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
        stepCe(2);
        checkOutput("hs_asl_low", 1'b0, 1'b1, 4'b0000, 1'b0);
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b1);
        stepCe(1);
        checkOutput("hs_busy", 1'b0, 1'b1, 4'b0000, 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b1);
        stepCe(1);
        checkOutput("hs_own", 1'b1, 1'b0, 4'b0001, 1'b1);

        $display("[TB] reset mid-OWN with ce low");
        ce     = 1'b0;
        resetl = 1'b0;
        @(posedge sysClk);
        #1;
        checkOutput("reset_mid_own", 1'b1, 1'b1, 4'b0000, 1'b0);
        resetl = 1'b1;

        $display("[TB] request withdrawn in REQ");
        applyStimulus(4'b0010, 1'b0, 1'b1, 1'b1);
        stepCe(1);
        checkOutput("withdraw_req", 1'b0, 1'b1, 4'b0000, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1);
        stepCe(1);
        checkOutput("withdraw_cpu", 1'b1, 1'b1, 4'b0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
